wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arb_pkg.sv | 38 +++
 rtl/wb_arb_rr.sv | 37 +++
 rtl/wb_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone arbiter:
//   - default address/data widths and watchdog limit
//   - FSM state encoding (IDLE / BUSY / GAP)
//   - one-hot grant constants (bit N = master N)
//   - rr_pick(): two-requester round-robin pick given the last-granted master
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int DEF_ADR_WIDTH = 16;
  localparam int DEF_DAT_WIDTH = 16;
  localparam int DEF_TIMEOUT   = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // last = 1 means master 1 was granted most recently, so a tie goes to m0.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    g = GNT_NONE;
    case (req)
      2'b01:   g = GNT_M0;
      2'b10:   g = GNT_M1;
      2'b11:   g = last ? GNT_M0 : GNT_M1;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_rr.sv
// ---------------------------------------------------------------------------
// wb_arb_rr
// Two-requester round-robin grant logic with a registered last-grant pointer.
// Ports:
//   i_wb_clk, i_wb_rst : clock, asynchronous active-high reset
//   req[1:0]           : request vector (bit N = master N)
//   upd                : update the last-grant pointer this cycle
//   upd_gnt[1:0]       : one-hot grant of the master that just finished
//   gnt[1:0]           : combinational one-hot pick for the current req
// The pointer resets to master 1 so master 0 wins the first tie.
// ---------------------------------------------------------------------------
module wb_arb_rr
  import wb_arb_pkg::*;
(
  input  logic       i_wb_clk,
  input  logic       i_wb_rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic [1:0] upd_gnt,
  output logic [1:0] gnt
);

  logic last_q;

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_gnt[1];
    end
  end

  always_comb begin
    gnt = rr_pick(req, last_q);
  end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Two-master to one-slave Wishbone arbiter with round-robin grant and a
// one-cycle GAP after every transfer (clears the slave's sticky ack).
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable a BUSY watchdog that
// aborts a transfer with o_mN_err after TIMEOUT BUSY cycles without ack.
//
// Ports:
//   i_wb_clk, i_wb_rst             : clock, asynchronous active-high reset
//   i_mN_cyc/stb/we/adr/data       : master N request (N = 0,1)
//   o_mN_ack/err/data              : master N response
//   o_s_cyc/stb/we/adr/data        : slave request (valid only in BUSY)
//   i_s_ack, i_s_data              : slave response
//   o_gnt[1:0]                     : registered one-hot grant, 00 when idle
//   o_dbg_state                    : current FSM state (debug)
//
// Handshake: a master requests with cyc&stb and holds them until it sees
// ack (or err); a transfer completes on the first BUSY cycle where the
// granted master still holds cyc and the slave asserts i_s_ack. Dropping cyc
// while granted aborts the transfer without an ack.
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADR_WIDTH = DEF_ADR_WIDTH,
  parameter int DAT_WIDTH = DEF_DAT_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 i_wb_clk,
  input  logic                 i_wb_rst,
  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  input  logic                 i_m0_we,
  input  logic [ADR_WIDTH-1:0] i_m0_adr,
  input  logic [DAT_WIDTH-1:0] i_m0_data,
  output logic                 o_m0_ack,
  output logic                 o_m0_err,
  output logic [DAT_WIDTH-1:0] o_m0_data,
  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  input  logic                 i_m1_we,
  input  logic [ADR_WIDTH-1:0] i_m1_adr,
  input  logic [DAT_WIDTH-1:0] i_m1_data,
  output logic                 o_m1_ack,
  output logic                 o_m1_err,
  output logic [DAT_WIDTH-1:0] o_m1_data,
  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  output logic                 o_s_we,
  output logic [ADR_WIDTH-1:0] o_s_adr,
  output logic [DAT_WIDTH-1:0] o_s_data,
  input  logic                 i_s_ack,
  input  logic [DAT_WIDTH-1:0] i_s_data,
  output logic [1:0]           o_gnt,
  output arb_state_e           o_dbg_state
);

  arb_state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] req;
  logic [1:0] rr_gnt;
  logic       rr_upd;
  logic       busy;

  // Granted master's signals, selected by the registered grant.
  logic                 g_cyc, g_stb, g_we;
  logic [ADR_WIDTH-1:0] g_adr;
  logic [DAT_WIDTH-1:0] g_data;

  logic ack_hit;
  logic abort_hit;
  logic timeout_hit;

  assign req  = {i_m1_cyc & i_m1_stb, i_m0_cyc & i_m0_stb};
  assign busy = (state_q == ST_BUSY);

  wb_arb_rr u_rr (
    .i_wb_clk (i_wb_clk),
    .i_wb_rst (i_wb_rst),
    .req      (req),
    .upd      (rr_upd),
    .upd_gnt  (gnt_q),
    .gnt      (rr_gnt)
  );

  always_comb begin
    g_cyc  = i_m0_cyc;
    g_stb  = i_m0_stb;
    g_we   = i_m0_we;
    g_adr  = i_m0_adr;
    g_data = i_m0_data;
    if (gnt_q[1]) begin
      g_cyc  = i_m1_cyc;
      g_stb  = i_m1_stb;
      g_we   = i_m1_we;
      g_adr  = i_m1_adr;
      g_data = i_m1_data;
    end
  end

  // Slave ack only counts while the granted master still holds cyc; an
  // abort in the same cycle takes precedence and produces no ack.
  assign ack_hit   = busy & g_cyc & i_s_ack;
  assign abort_hit = busy & ~g_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;

  // The counter reaches TIMEOUT on the cycle it would increment from
  // TIMEOUT-1, i.e. the TIMEOUT-th BUSY cycle. An ack in that cycle wins.
  assign timeout_hit = busy & g_cyc & ~i_s_ack & (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE && |req) begin
      cnt_q <= '0;
    end else if (busy && !i_s_ack && cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_NONE;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_upd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_BUSY;
          gnt_d   = rr_gnt;
        end
      end
      ST_BUSY: begin
        if (abort_hit || ack_hit || timeout_hit) begin
          state_d = ST_GAP;
          gnt_d   = GNT_NONE;
          rr_upd  = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_adr  = '0;
    o_s_data = '0;
    if (busy) begin
      o_s_cyc  = g_cyc;
      o_s_stb  = g_stb;
      o_s_we   = g_we;
      o_s_adr  = g_adr;
      o_s_data = g_data;
    end
  end

  assign o_m0_ack    = ack_hit & gnt_q[0];
  assign o_m1_ack    = ack_hit & gnt_q[1];
  assign o_m0_err    = timeout_hit & gnt_q[0];
  assign o_m1_err    = timeout_hit & gnt_q[1];
  assign o_m0_data   = gnt_q[0] ? i_s_data : '0;
  assign o_m1_data   = gnt_q[1] ? i_s_data : '0;
  assign o_gnt       = gnt_q;
  assign o_dbg_state = state_q;

endmodule
